// File: rtl/mega_ram_arbiter_if.sv
// Bus bundle for mega_ram_arbiter: the CPU request port, the DMA request port
// and the RAM-facing port. The arbiter connects through the slave modport and
// the surrounding system (requesters plus RAM) through the master modport.
interface mega_ram_arbiter_if #(
  parameter int ADDR_BUS_WIDTH = 13,
  parameter int DATA_BUS_WIDTH = 8
);

  logic                      cpu_cs;
  logic                      cpu_we;
  logic                      cpu_re;
  logic [ADDR_BUS_WIDTH-1:0] cpu_a;
  logic [DATA_BUS_WIDTH-1:0] cpu_d_in;
  logic [DATA_BUS_WIDTH-1:0] cpu_d_out;
  logic                      cpu_wait;

  logic                      dma_req;
  logic                      dma_we;
  logic [ADDR_BUS_WIDTH-1:0] dma_a;
  logic [DATA_BUS_WIDTH-1:0] dma_d_in;
  logic                      dma_gnt;
  logic [DATA_BUS_WIDTH-1:0] dma_d_out;
  logic                      dma_rvalid;

  logic                      ram_cs;
  logic                      ram_we;
  logic                      ram_re;
  logic [ADDR_BUS_WIDTH-1:0] ram_a;
  logic [DATA_BUS_WIDTH-1:0] ram_d_in;
  logic [DATA_BUS_WIDTH-1:0] ram_d_out;

  modport slave (
    input  cpu_cs, cpu_we, cpu_re, cpu_a, cpu_d_in,
    output cpu_d_out, cpu_wait,
    input  dma_req, dma_we, dma_a, dma_d_in,
    output dma_gnt, dma_d_out, dma_rvalid,
    output ram_cs, ram_we, ram_re, ram_a, ram_d_in,
    input  ram_d_out
  );

  modport master (
    output cpu_cs, cpu_we, cpu_re, cpu_a, cpu_d_in,
    input  cpu_d_out, cpu_wait,
    output dma_req, dma_we, dma_a, dma_d_in,
    input  dma_gnt, dma_d_out, dma_rvalid,
    input  ram_cs, ram_we, ram_re, ram_a, ram_d_in,
    output ram_d_out
  );

endinterface

// File: rtl/mega_ram_arbiter.sv
// Two-requester arbiter (CPU and DMA) in front of the single-port MEGA data
// RAM. The CPU has priority; the DMA takes idle slots. Reads have a one-cycle
// registered latency, and because the RAM gates its read data with the live
// cs & re, both are held high through the data phase and the returned byte is
// steered to whichever requester issued the read.
//
// Optional feature: define MEGA_RAM_ARB_STARVE_GUARD_EN to add a starvation
// guard that forces a DMA grant after STARVE_MAX consecutive denied cycles.
module mega_ram_arbiter #(
  parameter int ADDR_BUS_WIDTH = 13,
  parameter int DATA_BUS_WIDTH = 8,
  parameter int STARVE_MAX     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mega_ram_arbiter_if.slave    bus
);

  // The guard counter is 8 bits wide, so the threshold must fit in it.
  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_badStarveMax
    $error("mega_ram_arbiter: STARVE_MAX must be in 1..255");
  end

  logic                      w_cpuReq;
  logic                      w_dmaReq;
  logic                      w_force;
  logic                      w_issueCpu;
  logic                      w_issueDma;
  logic                      w_issueRead;
  logic                      w_ramWe;
  logic [ADDR_BUS_WIDTH-1:0] w_ramA;
  logic [DATA_BUS_WIDTH-1:0] w_ramDin;
  logic [DATA_BUS_WIDTH-1:0] w_cpuDout;
  logic [DATA_BUS_WIDTH-1:0] w_dmaDout;
  logic                      w_dmaRvalid;

  logic                      r_rdPend;
  logic                      r_rdOwn;

  assign w_cpuReq = bus.cpu_cs & (bus.cpu_we | bus.cpu_re);
  assign w_dmaReq = bus.dma_req;

`ifdef MEGA_RAM_ARB_STARVE_GUARD_EN
  localparam logic [7:0] LP_STARVE_MAX = 8'(STARVE_MAX);

  logic [7:0] r_starveCnt;

  // The guard only overrides priority when both sides are contending.
  assign w_force = (r_starveCnt == LP_STARVE_MAX) & w_cpuReq & w_dmaReq;

  // Count consecutive cycles the DMA waited without a grant; saturate at the
  // threshold and restart from zero whenever the DMA is finally served.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starveCnt <= 8'd0;
    end else if (w_issueDma) begin
      r_starveCnt <= 8'd0;
    end else if (w_dmaReq && (r_starveCnt != LP_STARVE_MAX)) begin
      r_starveCnt <= r_starveCnt + 8'd1;
    end
  end
`else
  assign w_force = 1'b0;
`endif

  // Same-cycle issue decision; everything is held off while reset is high.
  assign w_issueCpu  = ~rst & w_cpuReq & ~w_force;
  assign w_issueDma  = ~rst & w_dmaReq & (~w_cpuReq | w_force);
  assign w_issueRead = (w_issueCpu & bus.cpu_re) | (w_issueDma & ~bus.dma_we);

  // Route the issuing requester's address, write data and write enable.
  always_comb begin
    w_ramWe  = 1'b0;
    w_ramA   = '0;
    w_ramDin = '0;
    if (w_issueCpu) begin
      w_ramWe  = bus.cpu_we;
      w_ramA   = bus.cpu_a;
      w_ramDin = bus.cpu_d_in;
    end else if (w_issueDma) begin
      w_ramWe  = bus.dma_we;
      w_ramA   = bus.dma_a;
      w_ramDin = bus.dma_d_in;
    end
  end

  // Remember that a read was issued and by whom, so next cycle's data phase
  // keeps the RAM output enabled and knows where to send the byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdPend <= 1'b0;
      r_rdOwn  <= 1'b0;
    end else begin
      r_rdPend <= w_issueRead;
      r_rdOwn  <= w_issueDma & ~bus.dma_we;
    end
  end

  // Steer returned read data to its owner; the other side sees zero.
  always_comb begin
    w_cpuDout   = '0;
    w_dmaDout   = '0;
    w_dmaRvalid = 1'b0;
    if (!rst && r_rdPend) begin
      if (r_rdOwn) begin
        w_dmaDout   = bus.ram_d_out;
        w_dmaRvalid = 1'b1;
      end else begin
        w_cpuDout = bus.ram_d_out;
      end
    end
  end

  assign bus.ram_cs     = w_issueCpu | w_issueDma | (~rst & r_rdPend);
  assign bus.ram_re     = w_issueRead | (~rst & r_rdPend);
  assign bus.ram_we     = w_ramWe;
  assign bus.ram_a      = w_ramA;
  assign bus.ram_d_in   = w_ramDin;
  assign bus.cpu_wait   = ~rst & w_cpuReq & ~w_issueCpu;
  assign bus.cpu_d_out  = w_cpuDout;
  assign bus.dma_gnt    = w_issueDma;
  assign bus.dma_d_out  = w_dmaDout;
  assign bus.dma_rvalid = w_dmaRvalid;

endmodule

// File: tb/tb_mega_ram_arbiter.sv
// Testbench for mega_ram_arbiter with a behavioural single-port RAM (registered
// read, output gated by cs & re). Expected read data is queued when a read is
// driven and compared when its data phase arrives. The starvation scenario
// follows MEGA_RAM_ARB_STARVE_GUARD_EN the same way the design does.
module tb_mega_ram_arbiter;

  localparam int AW = 13;
  localparam int DW = 8;

  typedef struct {
    int         due;
    bit         own;
    logic [7:0] data;
  } sbEntry_t;

  logic clk;
  logic rst;
  int   checkCount = 0;
  int   errorCount = 0;
  int   cycleCnt   = 0;
  int   gntSeen    = 0;
  sbEntry_t sbQ[$];

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] ramQ;

  mega_ram_arbiter_if #(.ADDR_BUS_WIDTH(AW), .DATA_BUS_WIDTH(DW)) arbBus ();

  mega_ram_arbiter #(
    .ADDR_BUS_WIDTH(AW),
    .DATA_BUS_WIDTH(DW),
    .STARVE_MAX(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(arbBus)
  );

  // Behavioural RAM: write on cs & we, registered read on cs & re, and read
  // data visible only while cs & re are high.
  always @(posedge clk) begin
    if (arbBus.ram_cs && arbBus.ram_we) mem[arbBus.ram_a] <= arbBus.ram_d_in;
    if (arbBus.ram_cs && arbBus.ram_re) ramQ <= mem[arbBus.ram_a];
  end
  assign arbBus.ram_d_out = (arbBus.ram_cs && arbBus.ram_re) ? ramQ : 8'h00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h", tag, cycleCnt, obs, exp);
    end
  endtask

  task automatic expectRead(input bit own, input logic [7:0] data);
    sbEntry_t e;
    e.due  = cycleCnt + 1;
    e.own  = own;
    e.data = data;
    sbQ.push_back(e);
  endtask

  // Drive one cycle of inputs just after the clock edge, let it settle, then
  // score any read data phase that is due in this cycle.
  task automatic applyStimulus(input bit r,
                               input bit cCs, input bit cWe, input bit cRe,
                               input logic [AW-1:0] cA, input logic [DW-1:0] cD,
                               input bit dReq, input bit dWe,
                               input logic [AW-1:0] dA, input logic [DW-1:0] dD);
    sbEntry_t e;
    @(posedge clk);
    #1;
    rst             = r;
    arbBus.cpu_cs   = cCs;
    arbBus.cpu_we   = cWe;
    arbBus.cpu_re   = cRe;
    arbBus.cpu_a    = cA;
    arbBus.cpu_d_in = cD;
    arbBus.dma_req  = dReq;
    arbBus.dma_we   = dWe;
    arbBus.dma_a    = dA;
    arbBus.dma_d_in = dD;
    cycleCnt++;
    #2;
    if (sbQ.size() > 0 && sbQ[0].due == cycleCnt) begin
      e = sbQ.pop_front();
      if (e.own) begin
        checkOutput("dmaRvalid", {31'd0, arbBus.dma_rvalid}, 32'd1);
        checkOutput("dmaData", {24'd0, arbBus.dma_d_out}, {24'd0, e.data});
        checkOutput("cpuDataNonOwner", {24'd0, arbBus.cpu_d_out}, 32'd0);
      end else begin
        checkOutput("cpuData", {24'd0, arbBus.cpu_d_out}, {24'd0, e.data});
        checkOutput("dmaRvalidNonOwner", {31'd0, arbBus.dma_rvalid}, 32'd0);
        checkOutput("dmaDataNonOwner", {24'd0, arbBus.dma_d_out}, 32'd0);
      end
    end else begin
      checkOutput("noRvalid", {31'd0, arbBus.dma_rvalid}, 32'd0);
      checkOutput("cpuDataIdle", {24'd0, arbBus.cpu_d_out}, 32'd0);
    end
  endtask

  task automatic idle(input bit r);
    applyStimulus(r, 0, 0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  initial begin
    int  starveCycles;
    bit  expGnt;

    rst = 1'b1;
    arbBus.cpu_cs = 0; arbBus.cpu_we = 0; arbBus.cpu_re = 0;
    arbBus.cpu_a = '0; arbBus.cpu_d_in = '0;
    arbBus.dma_req = 0; arbBus.dma_we = 0; arbBus.dma_a = '0; arbBus.dma_d_in = '0;

    // Reset with both requesters active: every output must stay low.
    applyStimulus(1, 1, 0, 1, 13'h0010, 8'h00, 1, 0, 13'h0020, 8'h00);
    checkOutput("rstCpuWait", {31'd0, arbBus.cpu_wait}, 32'd0);
    checkOutput("rstDmaGnt", {31'd0, arbBus.dma_gnt}, 32'd0);
    checkOutput("rstRamCs", {31'd0, arbBus.ram_cs}, 32'd0);
    checkOutput("rstRamRe", {31'd0, arbBus.ram_re}, 32'd0);
    idle(1);

    // CPU write 0x0010 = 0x5A.
    applyStimulus(0, 1, 1, 0, 13'h0010, 8'h5A, 0, 0, '0, '0);
    checkOutput("wrRamCs", {31'd0, arbBus.ram_cs}, 32'd1);
    checkOutput("wrRamWe", {31'd0, arbBus.ram_we}, 32'd1);
    checkOutput("wrRamRe", {31'd0, arbBus.ram_re}, 32'd0);
    checkOutput("wrRamA", {19'd0, arbBus.ram_a}, 32'h0010);
    checkOutput("wrRamD", {24'd0, arbBus.ram_d_in}, 32'h5A);
    idle(0);
    checkOutput("idleRamCs", {31'd0, arbBus.ram_cs}, 32'd0);

    // DMA writes to preload 0x0001 and 0x0002.
    applyStimulus(0, 0, 0, 0, '0, '0, 1, 1, 13'h0001, 8'h11);
    checkOutput("dmaWrGnt", {31'd0, arbBus.dma_gnt}, 32'd1);
    applyStimulus(0, 0, 0, 0, '0, '0, 1, 1, 13'h0002, 8'h22);
    checkOutput("dmaWrA", {19'd0, arbBus.ram_a}, 32'h0002);

    // CPU read 0x0010, then its data phase.
    applyStimulus(0, 1, 0, 1, 13'h0010, 8'h00, 0, 0, '0, '0);
    checkOutput("rdRamRe", {31'd0, arbBus.ram_re}, 32'd1);
    checkOutput("rdCpuWait", {31'd0, arbBus.cpu_wait}, 32'd0);
    expectRead(0, 8'h5A);
    idle(0);
    checkOutput("rdPhaseRamRe", {31'd0, arbBus.ram_re}, 32'd1);

    // CPU write 0x0020 = 0xC3 contends with a DMA read of 0x0020.
    applyStimulus(0, 1, 1, 0, 13'h0020, 8'hC3, 1, 0, 13'h0020, 8'h00);
    checkOutput("contendGnt", {31'd0, arbBus.dma_gnt}, 32'd0);
    checkOutput("contendWait", {31'd0, arbBus.cpu_wait}, 32'd0);
    applyStimulus(0, 0, 0, 0, '0, '0, 1, 0, 13'h0020, 8'h00);
    checkOutput("dmaRdGnt", {31'd0, arbBus.dma_gnt}, 32'd1);
    expectRead(1, 8'hC3);
    idle(0);

    // Alternating CPU/DMA reads, fully pipelined.
    applyStimulus(0, 1, 0, 1, 13'h0001, 8'h00, 0, 0, '0, '0);
    expectRead(0, 8'h11);
    applyStimulus(0, 0, 0, 0, '0, '0, 1, 0, 13'h0002, 8'h00);
    checkOutput("altRe1", {31'd0, arbBus.ram_re}, 32'd1);
    expectRead(1, 8'h22);
    applyStimulus(0, 1, 0, 1, 13'h0001, 8'h00, 0, 0, '0, '0);
    checkOutput("altRe2", {31'd0, arbBus.ram_re}, 32'd1);
    expectRead(0, 8'h11);
    idle(0);
    checkOutput("altRe3", {31'd0, arbBus.ram_re}, 32'd1);
    idle(0);
    checkOutput("altReOff", {31'd0, arbBus.ram_re}, 32'd0);

    // Write issued during a read data phase keeps ram_re high.
    applyStimulus(0, 1, 0, 1, 13'h0010, 8'h00, 0, 0, '0, '0);
    expectRead(0, 8'h5A);
    applyStimulus(0, 0, 0, 0, '0, '0, 1, 1, 13'h0003, 8'h33);
    checkOutput("wrInPhaseWe", {31'd0, arbBus.ram_we}, 32'd1);
    checkOutput("wrInPhaseRe", {31'd0, arbBus.ram_re}, 32'd1);
    applyStimulus(0, 1, 0, 1, 13'h0003, 8'h00, 0, 0, '0, '0);
    expectRead(0, 8'h33);
    idle(0);

    // Combined write+read, then an immediate DMA read of the same address.
    applyStimulus(0, 1, 1, 0, 13'h0004, 8'h44, 0, 0, '0, '0);
    applyStimulus(0, 1, 1, 1, 13'h0004, 8'h44, 0, 0, '0, '0);
    checkOutput("weReBoth", {30'd0, arbBus.ram_we, arbBus.ram_re}, 32'd3);
    expectRead(0, 8'h44);
    applyStimulus(0, 1, 1, 0, 13'h0005, 8'h55, 0, 0, '0, '0);
    applyStimulus(0, 0, 0, 0, '0, '0, 1, 0, 13'h0005, 8'h00);
    expectRead(1, 8'h55);
    idle(0);

    // Reset lands on a DMA read data phase: the data phase is discarded.
    applyStimulus(0, 0, 0, 0, '0, '0, 1, 0, 13'h0002, 8'h00);
    checkOutput("preRstGnt", {31'd0, arbBus.dma_gnt}, 32'd1);
    idle(1);
    checkOutput("midRstRvalid", {31'd0, arbBus.dma_rvalid}, 32'd0);
    checkOutput("midRstRamCs", {31'd0, arbBus.ram_cs}, 32'd0);
    idle(0);
    checkOutput("postRstRamCs", {31'd0, arbBus.ram_cs}, 32'd0);

    // Continuous contention: CPU reads 0x0001, DMA reads 0x0002.
`ifdef MEGA_RAM_ARB_STARVE_GUARD_EN
    starveCycles = 20;
`else
    starveCycles = 100;
`endif
    for (int i = 1; i <= starveCycles; i++) begin
      applyStimulus(0, 1, 0, 1, 13'h0001, 8'h00, 1, 0, 13'h0002, 8'h00);
`ifdef MEGA_RAM_ARB_STARVE_GUARD_EN
      expGnt = (i % 4) == 0;
`else
      expGnt = 1'b0;
`endif
      checkOutput("starveGnt", {31'd0, arbBus.dma_gnt}, {31'd0, expGnt});
      checkOutput("starveWait", {31'd0, arbBus.cpu_wait}, {31'd0, expGnt});
      if (arbBus.dma_gnt) gntSeen++;
      if (expGnt) expectRead(1, 8'h22);
      else        expectRead(0, 8'h11);
    end
`ifdef MEGA_RAM_ARB_STARVE_GUARD_EN
    checkOutput("starveGntTotal", gntSeen, starveCycles / 4);
`else
    checkOutput("starveGntTotal", gntSeen, 0);
`endif
    idle(0);
    idle(0);
    checkOutput("sbDrained", sbQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
